// File: rtl/mem_responder_if.sv
// Split instruction/data memory bus between the CPU (master) and the memory model (slave).
// Requests are held by the master until the matching one-cycle resp pulse.
interface mem_responder_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output imem_address, imem_read,
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_address, imem_read,
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_responder.sv
// Single-ported word memory serving imem fetches and dmem loads/stores with a fixed
// programmable latency; fair arbitration keeps either port from starving the other.
module mem_responder #(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mem_responder: LATENCY must be within 1..15");
        end
    endgenerate

    logic [3:0][7:0]   mem [DEPTH];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              last_dmem;
    logic              sel_d;
    logic              sel_rd;
    logic [ADDR_W-1:0] idx_q;
    logic              imem_resp_q;
    logic              dmem_resp_q;
    logic [31:0]       imem_rdata_q;
    logic [31:0]       dmem_rdata_q;

    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic              accept;
    logic              do_store;
    logic              enter_resp;
    logic              resp_d;
    logic              resp_rd;
    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;

    // Byte offset and bits above the array index are don't-care: addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.imem_address[31:ADDR_W+2], bus.imem_address[1:0],
                                bus.dmem_address[31:ADDR_W+2], bus.dmem_address[1:0]};

    always_comb begin
        i_idx    = bus.imem_address[ADDR_W+1:2];
        d_idx    = bus.dmem_address[ADDR_W+1:2];
        d_req    = bus.dmem_read | bus.dmem_write;
        // dmem wins unless it also won last time and imem is waiting.
        grant_i  = (state == IDLE) && bus.imem_read && (!d_req || last_dmem);
        grant_d  = (state == IDLE) && d_req && !grant_i;
        accept   = grant_i | grant_d;
        do_store = grant_d && bus.dmem_write && !rst;

        enter_resp = (accept && (CNT_INIT == 4'd0)) || ((state == BUSY) && (cnt == 4'd1));
        resp_d     = (state == IDLE) ? grant_d : sel_d;
        resp_rd    = (state == IDLE) ? (grant_i || bus.dmem_read) : sel_rd;
        rd_idx     = (state == IDLE) ? (grant_d ? d_idx : i_idx) : idx_q;

        // With LATENCY=1 the accept edge is also the RESP edge, so fold in the store here.
        rd_word = mem[rd_idx];
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_wmask[b]) rd_word[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_wmask[b]) mem[d_idx][b] <= bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            last_dmem    <= 1'b0;
            sel_d        <= 1'b0;
            sel_rd       <= 1'b0;
            idx_q        <= '0;
            imem_resp_q  <= 1'b0;
            dmem_resp_q  <= 1'b0;
            imem_rdata_q <= 32'd0;
            dmem_rdata_q <= 32'd0;
        end else begin
            imem_resp_q <= enter_resp && !resp_d;
            dmem_resp_q <= enter_resp && resp_d;
            // Pure stores leave dmem_rdata holding the last load result.
            if (enter_resp && resp_rd) begin
                if (resp_d) dmem_rdata_q <= rd_word;
                else        imem_rdata_q <= rd_word;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_d     <= grant_d;
                        sel_rd    <= grant_i || bus.dmem_read;
                        idx_q     <= rd_idx;
                        last_dmem <= grant_d;
                        cnt       <= CNT_INIT;
                        state     <= (CNT_INIT == 4'd0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_resp  = imem_resp_q;
    assign bus.dmem_resp  = dmem_resp_q;
    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction-level model predicts resp timing and data
// every cycle, and literal expectations pin the model on the main scenarios.
module tb_mem_responder;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus4 ();

    mem_responder #(.ADDR_W(10), .LATENCY(L), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_responder #(.ADDR_W(10), .LATENCY(4), .INIT_FILE("")) dut4 (
        .clk(clk), .rst(rst4), .bus(bus4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one request at a time, response L cycles after acceptance,
    // next acceptance the cycle after the response.
    logic [31:0] mm [1024];
    int          resp_cyc = -1;
    int          free_cyc = 0;
    bit          resp_is_d, resp_rd, m_last_d, take_d, dq, iq;
    logic [31:0] resp_data, last_i = 0, last_d = 0;
    logic [9:0]  a;

    always @(negedge clk) begin
        if (rst) begin
            resp_cyc = -1;
            free_cyc = 0;
            m_last_d = 0;
            last_i   = 32'd0;
            last_d   = 32'd0;
        end else begin
            if (resp_cyc == cyc) begin
                if (!resp_is_d)  last_i = resp_data;
                else if (resp_rd) last_d = resp_data;
            end
            chk("imem_resp", 32'(bus.imem_resp), 32'(resp_cyc == cyc && !resp_is_d));
            chk("dmem_resp", 32'(bus.dmem_resp), 32'(resp_cyc == cyc && resp_is_d));
            chk("imem_rdata", bus.imem_rdata, last_i);
            chk("dmem_rdata", bus.dmem_rdata, last_d);
            if (cyc >= free_cyc) begin
                dq = bus.dmem_read | bus.dmem_write;
                iq = bus.imem_read;
                if (dq || iq) begin
                    take_d   = dq && !(iq && m_last_d);
                    m_last_d = take_d;
                    if (take_d) begin
                        a = bus.dmem_address[11:2];
                        if (bus.dmem_write)
                            for (int b = 0; b < 4; b++)
                                if (bus.dmem_wmask[b]) mm[a][8*b +: 8] = bus.dmem_wdata[8*b +: 8];
                        resp_rd = bus.dmem_read;
                    end else begin
                        a = bus.imem_address[11:2];
                        resp_rd = 1;
                    end
                    resp_data = mm[a];
                    resp_is_d = take_d;
                    resp_cyc  = cyc + L;
                    free_cyc  = cyc + L + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the resp cycle; which: 0 imem, 1 dmem, 2 dmem of dut4.
    task automatic wait_resp(input int which, output int at);
        logic r;
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            r = (which == 0) ? bus.imem_resp : (which == 1) ? bus.dmem_resp : bus4.dmem_resp;
            if (r) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: port %0d got no resp within 40 cycles", which);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input bit rd);
        int at;
        bus.dmem_address = addr;
        bus.dmem_wdata   = data;
        bus.dmem_wmask   = mask;
        bus.dmem_write   = 1'b1;
        bus.dmem_read    = rd;
        wait_resp(1, at);
        tick();
        bus.dmem_write = 1'b0;
        bus.dmem_read  = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        int at;
        bus.dmem_address = addr;
        bus.dmem_read    = 1'b1;
        wait_resp(1, at);
        data = bus.dmem_rdata;
        tick();
        bus.dmem_read = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] data);
        int at;
        bus.imem_address = addr;
        bus.imem_read    = 1'b1;
        wait_resp(0, at);
        data = bus.imem_rdata;
        tick();
        bus.imem_read = 1'b0;
    endtask

    initial begin
        int          t0, r1, r2, n;
        int          rc[4];
        bit          rp[4];
        logic [31:0] v;

        bus.imem_address = 0; bus.imem_read = 0;
        bus.dmem_address = 0; bus.dmem_read = 0; bus.dmem_write = 0;
        bus.dmem_wmask = 0; bus.dmem_wdata = 0;
        bus4.imem_address = 0; bus4.imem_read = 0;
        bus4.dmem_address = 0; bus4.dmem_read = 0; bus4.dmem_write = 0;
        bus4.dmem_wmask = 0; bus4.dmem_wdata = 0;

        repeat (3) tick();
        chk("rst_imem_resp", 32'(bus.imem_resp), 32'd0);
        chk("rst_dmem_resp", 32'(bus.dmem_resp), 32'd0);
        chk("rst_imem_rdata", bus.imem_rdata, 32'd0);
        chk("rst_dmem_rdata", bus.dmem_rdata, 32'd0);
        rst  = 1'b0;
        rst4 = 1'b0;

        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(bus.imem_resp) + int'(bus.dmem_resp) + int'(bus4.dmem_resp);
        end
        chk("idle_no_resp", 32'(n), 32'd0);
        tick();

        // Fetch latency and back-to-back acceptance of a held fetch.
        store(32'h10, 32'h0050_0093, 4'hF, 1'b0);
        bus.imem_address = 32'h10;
        bus.imem_read    = 1'b1;
        t0 = cyc;
        wait_resp(0, r1);
        chk("fetch_latency", 32'(r1 - t0), 32'd2);
        chk("fetch_data", bus.imem_rdata, 32'h0050_0093);
        wait_resp(0, r2);
        chk("fetch_reaccept", 32'(r2 - t0), 32'd5);
        tick();
        bus.imem_read = 1'b0;

        // Masked store then load.
        store(32'h20, 32'h1122_3344, 4'hF, 1'b0);
        store(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
        load(32'h20, v);
        chk("masked_store", v, 32'h11BB_33DD);

        // Arbitration: clear last_dmem with a fetch, then raise both together and hold.
        fetch(32'h10, v);
        bus.imem_address = 32'h10;
        bus.dmem_address = 32'h20;
        bus.imem_read    = 1'b1;
        bus.dmem_read    = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.dmem_resp) begin rp[n] = 1; rc[n] = cyc; n++; end
            else if (bus.imem_resp) begin rp[n] = 0; rc[n] = cyc; n++; end
        end
        chk("arb_count", 32'(n), 32'd4);
        if (n == 4) begin
            chk("arb_0_is_d", 32'(rp[0]), 32'd1);
            chk("arb_1_is_i", 32'(rp[1]), 32'd0);
            chk("arb_2_is_d", 32'(rp[2]), 32'd1);
            chk("arb_3_is_i", 32'(rp[3]), 32'd0);
            for (int k = 1; k < 4; k++) chk("arb_spacing", 32'(rc[k] - rc[k-1]), 32'(L + 1));
        end
        tick();
        bus.imem_read = 1'b0;
        bus.dmem_read = 1'b0;

        // Aliasing beyond depth and ignored byte offset.
        store(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        fetch(32'h0000_0004, v);
        chk("alias_fetch_4", v, 32'hDEAD_BEEF);
        fetch(32'h0000_0007, v);
        chk("alias_fetch_7", v, 32'hDEAD_BEEF);

        // Read+write returns the post-write word; empty mask still completes.
        store(32'h8, 32'h0102_0304, 4'hF, 1'b0);
        store(32'h8, 32'h9988_7766, 4'b0011, 1'b1);
        chk("rw_post_write", bus.dmem_rdata, 32'h0102_7766);
        store(32'h8, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        load(32'h8, v);
        chk("wmask_zero", v, 32'h0102_7766);

        // Asynchronous reset mid-cycle while a fetch is in flight.
        bus.imem_address = 32'h10;
        bus.imem_read    = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_imem_resp", 32'(bus.imem_resp), 32'd0);
        chk("async_rst_dmem_resp", 32'(bus.dmem_resp), 32'd0);
        chk("async_rst_imem_rdata", bus.imem_rdata, 32'd0);
        chk("async_rst_dmem_rdata", bus.dmem_rdata, 32'd0);
        bus.imem_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        load(32'h20, v);
        chk("mem_survives_rst", v, 32'h11BB_33DD);

        // LATENCY=4 instance: reset while BUSY drops the resp but keeps the store.
        bus4.dmem_address = 32'h40;
        bus4.dmem_wdata   = 32'hCAFE_F00D;
        bus4.dmem_wmask   = 4'hF;
        bus4.dmem_write   = 1'b1;
        tick();
        tick();
        #2 rst4 = 1'b1;
        bus4.dmem_write = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(bus4.dmem_resp);
        end
        chk("l4_dropped_resp", 32'(n), 32'd0);
        tick();
        rst4 = 1'b0;
        bus4.dmem_read = 1'b1;
        t0 = cyc;
        wait_resp(2, r1);
        chk("l4_latency", 32'(r1 - t0), 32'd4);
        chk("l4_store_kept", bus4.dmem_rdata, 32'hCAFE_F00D);
        tick();
        bus4.dmem_read = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
